mul_div_unit: RTL and testbench

- Iterative RV64M multiply/divide unit in the EX stage.
- Accepts one M-extension op from EX and raises stall_req_o. The EX stage wires stall_req_o to the pipeline controller's mul/div stall input, which stalls PC/Pre_IF/IF_ID and flushes EX_MEM.
- Delivers a one-cycle result_valid_o when the result is ready; a trap flush aborts the operation.

---
 rtl/mul_div_unit.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit in the EX stage.
// Latency: N+1 cycles from accept to result_valid (N = 32 for word ops, XLEN otherwise); 1 cycle for div-by-zero and overflow.
// Backpressure: stall_req_o holds the pipeline from accept until the op finishes; flush_i aborts the op.
module mul_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(31);
    localparam logic [CW-1:0] LAST_FULL = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Sign-extend a 32-bit value to the full datapath width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Zero-extend a 32-bit value to the full datapath width.
    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    // ------------------------------------------------------------------
    // Accept-side decode, operating directly on the EX inputs
    // ------------------------------------------------------------------
    logic            accept;
    logic            word_eff;
    logic            s1_signed;
    logic            s2_signed;
    logic [XLEN-1:0] opnd1;
    logic [XLEN-1:0] opnd2;
    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [XLEN-1:0] min_val;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    // Operand preparation: effective width, signedness, magnitudes and the two shortcut cases.
    always_comb begin
        accept    = (state == IDLE) && valid_i && !flush_i;
        // MULH/MULHSU/MULHU have no W form; a stray word flag is ignored for them.
        word_eff  = word_i && (op_i[2] || (op_i[1:0] == 2'd0));
        s1_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
        s2_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);

        if (word_eff) begin
            opnd1 = s1_signed ? sext32(src1_i[31:0]) : zext32(src1_i[31:0]);
            opnd2 = s2_signed ? sext32(src2_i[31:0]) : zext32(src2_i[31:0]);
        end else begin
            opnd1 = src1_i;
            opnd2 = src2_i;
        end

        sign1 = s1_signed && opnd1[XLEN-1];
        sign2 = s2_signed && opnd2[XLEN-1];
        mag1  = sign1 ? -opnd1 : opnd1;
        mag2  = sign2 ? -opnd2 : opnd2;

        // Most-negative value of the effective width, sign-extended.
        min_val = word_eff ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};

        div_zero = op_i[2] && (opnd2 == '0);
        div_ovf  = op_i[2] && s1_signed && (opnd1 == min_val) && (opnd2 == '1);
        special  = div_zero || div_ovf;

        // op_i[1] selects remainder (REM/REMU) over quotient (DIV/DIVU).
        special_res = '0;
        if (div_zero) begin
            special_res = op_i[1] ? (word_eff ? sext32(src1_i[31:0]) : src1_i) : '1;
        end else if (div_ovf) begin
            special_res = op_i[1] ? '0 : opnd1;
        end
    end

    // ------------------------------------------------------------------
    // Latched operation state and iteration registers
    // ------------------------------------------------------------------
    logic [2:0]        op_q;
    logic              word_q;
    logic              sign1_q;
    logic              sign2_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   dquo;
    logic [XLEN-1:0]   drem;
    logic [XLEN-1:0]   dvsr;

    logic              last;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     rem_shift;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_diff;
    logic [XLEN-1:0]   drem_nxt;
    logic [XLEN-1:0]   dquo_nxt;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   div_raw;
    logic [XLEN-1:0]   div_res;

    // One shift-add step, one restoring-division step, and the final sign fix-up of each.
    always_comb begin
        last = (cnt == (word_q ? LAST_WORD : LAST_FULL));

        // Multiply: add the shifted multiplicand when the current multiplier bit is set.
        acc_nxt = acc + (mplier[0] ? mcand : '0);
        prod_s  = (sign1_q ^ sign2_q) ? -acc_nxt : acc_nxt;
        if (op_q == 3'd0) begin
            mul_res = word_q ? sext32(prod_s[31:0]) : prod_s[XLEN-1:0];
        end else begin
            mul_res = prod_s[2*XLEN-1:XLEN];
        end

        // Divide: bring down the next dividend bit and subtract when it fits.
        // Word ops pre-shift the dividend so its bit 31 is consumed first.
        rem_shift = {drem, dquo[XLEN-1]};
        rem_ge    = (rem_shift >= {1'b0, dvsr});
        rem_diff  = rem_shift[XLEN-1:0] - dvsr;
        drem_nxt  = rem_ge ? rem_diff : rem_shift[XLEN-1:0];
        dquo_nxt  = {dquo[XLEN-2:0], rem_ge};

        quo_s   = (sign1_q ^ sign2_q) ? -dquo_nxt : dquo_nxt;
        rem_s   = sign1_q ? -drem_nxt : drem_nxt;
        div_raw = op_q[1] ? rem_s : quo_s;
        div_res = word_q ? sext32(div_raw[31:0]) : div_raw;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs; flush wins over both accept and completion.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = op_i[2] ? DIV : MUL;
                    end
                end
            end
            MUL, DIV: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Gated by rst so the stall drops the moment reset asserts, even with valid_i high.
        stall_req_o    = !rst && (accept || (state == MUL) || (state == DIV));
        result_valid_o = (state == DONE);
    end

    // Datapath: latch operands on accept, iterate while busy, capture the result on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            word_q   <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            dquo     <= '0;
            drem     <= '0;
            dvsr     <= '0;
            result_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_i;
                        word_q  <= word_eff;
                        sign1_q <= sign1;
                        sign2_q <= sign2;
                        cnt     <= '0;
                        acc     <= '0;
                        mcand   <= {{XLEN{1'b0}}, mag1};
                        mplier  <= mag2;
                        dquo    <= word_eff ? (mag1 << (XLEN - 32)) : mag1;
                        drem    <= '0;
                        dvsr    <= mag2;
                        if (special) begin
                            result_o <= special_res;
                        end
                    end
                end
                MUL: begin
                    if (!flush_i) begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (last) begin
                            result_o <= mul_res;
                        end
                    end
                end
                DIV: begin
                    if (!flush_i) begin
                        dquo <= dquo_nxt;
                        drem <= drem_nxt;
                        cnt  <= cnt + 1'b1;
                        if (last) begin
                            result_o <= div_res;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus flush, reset and back-to-back sequences.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [2:0]  op_i;
    logic        word_i;
    logic [63:0] src1_i;
    logic [63:0] src2_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        result_valid_o;
    logic [63:0] result_o;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;

    mul_div_unit #(.XLEN(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .op_i          (op_i),
        .word_i        (word_i),
        .src1_i        (src1_i),
        .src2_i        (src2_i),
        .flush_i       (flush_i),
        .stall_req_o   (stall_req_o),
        .result_valid_o(result_valid_o),
        .result_o      (result_o)
    );

    always #5 clk = ~clk;

    // Count result pulses independently of the sequences.
    always @(negedge clk) begin
        if (result_valid_o === 1'b1) pulse_cnt++;
    end

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          stalls;
    } vec_t;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one op, drop valid after the accept edge, and wait for the result pulse.
    task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res,
                          output int lat, output int stalls, output bit ok);
        int c;
        bit done;
        @(negedge clk);
        op_i = op; word_i = w; src1_i = a; src2_i = b; valid_i = 1'b1;
        #1;
        c = 0; done = 1'b0; lat = -1; stalls = 0; res = 'x;
        while (!done && c < 200) begin
            if (stall_req_o) stalls++;
            if (result_valid_o) begin
                done = 1'b1;
                lat = c;
                res = result_o;
            end else begin
                @(posedge clk); #1;
                if (c == 0) begin
                    valid_i = 1'b0;
                    op_i    = 3'($urandom);
                    word_i  = 1'($urandom);
                    src1_i  = {$urandom, $urandom};
                    src2_i  = {$urandom, $urandom};
                end
                @(negedge clk); #1;
                c++;
            end
        end
        ok = done;
    endtask

    vec_t vecs[$];

    initial begin
        logic [63:0] res;
        logic [63:0] prev;
        int lat;
        int stalls;
        int p0;
        int nres;
        int first_c;
        int drop_c;
        bit ok;

        // op, word, src1, src2, expected, stall cycles (= cycles from accept to result)
        vecs.push_back('{3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65});
        vecs.push_back('{3'd3, 1'b0, ONES, 64'd2, 64'd1, 65});
        vecs.push_back('{3'd1, 1'b0, ONES, ONES, 64'd0, 65});
        vecs.push_back('{3'd2, 1'b0, ONES, 64'd2, ONES, 65});
        vecs.push_back('{3'd4, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1});
        vecs.push_back('{3'd6, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'd0, 1});
        vecs.push_back('{3'd5, 1'b0, 64'd100, 64'd0, ONES, 1});
        vecs.push_back('{3'd6, 1'b0, -64'sd7, 64'd0, -64'sd7, 1});
        vecs.push_back('{3'd6, 1'b0, -64'sd7, 64'd2, ONES, 65});
        vecs.push_back('{3'd4, 1'b0, -64'sd7, 64'd2, -64'sd3, 65});
        vecs.push_back('{3'd0, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33});
        vecs.push_back('{3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h0000_0000_0FFF_FFFF, 33});
        vecs.push_back('{3'd7, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd10, 64'd5, 33});
        vecs.push_back('{3'd4, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1});
        vecs.push_back('{3'd6, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 1});
        vecs.push_back('{3'd4, 1'b1, 64'h0000_0000_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33});
        vecs.push_back('{3'd6, 1'b1, 64'h0000_0000_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33});
        vecs.push_back('{3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65});
        vecs.push_back('{3'd5, 1'b0, ONES, 64'd3, 64'h5555_5555_5555_5555, 65});
        vecs.push_back('{3'd7, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'hFFFF_FFFF_9ABC_DEF0, 1});
        vecs.push_back('{3'd0, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 65});
        // MULH with a stray word flag behaves as the 64-bit MULH.
        vecs.push_back('{3'd1, 1'b1, 64'h8000_0000_0000_0000, 64'd2, ONES, 65});
        vecs.push_back('{3'd7, 1'b0, ONES, 64'h10, 64'hF, 65});

        // Reset state, with valid_i high to show the stall is held off by reset.
        rst = 1'b1; valid_i = 1'b1; op_i = 3'd0; word_i = 1'b0;
        src1_i = 64'd3; src2_i = 64'd4; flush_i = 1'b0;
        #12;
        check("reset stall", 64'(stall_req_o), 64'd0);
        check("reset valid", 64'(result_valid_o), 64'd0);
        check("reset result", result_o, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b0;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, res, lat, stalls, ok);
            check($sformatf("v%0d op%0d done", i, vecs[i].op), 64'(ok), 64'd1);
            check($sformatf("v%0d op%0d result", i, vecs[i].op), res, vecs[i].exp);
            check($sformatf("v%0d op%0d latency", i, vecs[i].op), 64'(lat), 64'(vecs[i].stalls));
            check($sformatf("v%0d op%0d stall cycles", i, vecs[i].op), 64'(stalls), 64'(vecs[i].stalls));
            @(negedge clk); #1;
            check($sformatf("v%0d one-cycle pulse", i), 64'(result_valid_o), 64'd0);
            check($sformatf("v%0d result held", i), result_o, vecs[i].exp);
        end

        // Flush at iteration 20 of a DIV, then a MUL presented the following cycle.
        prev = result_o;
        p0 = pulse_cnt;
        @(negedge clk);
        op_i = 3'd4; word_i = 1'b0; src1_i = -64'sd7; src2_i = 64'd2; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); #1;
        check("flush pre stall", 64'(stall_req_o), 64'd1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush stall drop", 64'(stall_req_o), 64'd0);
        check("flush no valid", 64'(result_valid_o), 64'd0);
        check("flush result kept", result_o, prev);
        run_op(3'd0, 1'b0, 64'd7, -64'sd3, res, lat, stalls, ok);
        check("post-flush mul result", res, 64'hFFFF_FFFF_FFFF_FFEB);
        check("post-flush mul latency", 64'(lat), 64'd65);
        check("flush pulse count", 64'(pulse_cnt - p0), 64'd1);

        // Reset at iteration 10 of a MULW.
        @(negedge clk);
        op_i = 3'd0; word_i = 1'b1; src1_i = 64'd5; src2_i = 64'd6; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); #1;
        check("pre-reset stall", 64'(stall_req_o), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("mid reset stall", 64'(stall_req_o), 64'd0);
        check("mid reset result", result_o, 64'd0);
        check("mid reset valid", 64'(result_valid_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back MUL then DIV with valid_i held across both.
        p0 = pulse_cnt;
        nres = 0; first_c = -1; drop_c = -1;
        @(negedge clk);
        op_i = 3'd0; word_i = 1'b0; src1_i = 64'd7; src2_i = -64'sd3; valid_i = 1'b1;
        #1;
        for (int c = 0; c < 250; c++) begin
            if (result_valid_o) begin
                nres++;
                if (nres == 1) begin
                    first_c = c;
                    drop_c = c + 1;
                    check("b2b mul result", result_o, 64'hFFFF_FFFF_FFFF_FFEB);
                    check("b2b mul latency", 64'(c), 64'd65);
                end else if (nres == 2) begin
                    check("b2b div result", result_o, -64'sd3);
                    check("b2b div latency", 64'(c - first_c), 64'd66);
                end
            end
            @(posedge clk); #1;
            if (c == 0) begin
                op_i = 3'd4; src1_i = -64'sd7; src2_i = 64'd2;
            end
            if (c == drop_c) valid_i = 1'b0;
            @(negedge clk); #1;
        end
        check("b2b pulse count", 64'(pulse_cnt - p0), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
